// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields and status flags in,
// strobes and mux selects out. master is the control unit side.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 3
);
    logic [5:0]            op_code;
    logic [5:0]            funct;
    logic                  zero;
    logic                  mem_ready;

    logic                  mem_read;
    logic                  mem_write;
    logic                  iord;
    logic                  ir_write;
    logic                  pc_write;
    logic [1:0]            pc_src;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  reg_dest;
    logic                  mem_reg;
    logic                  reg_write;
    logic                  trap;
    logic [3:0]            state_o;

    modport master (
        input  op_code, funct, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_dest, mem_reg,
               reg_write, trap, state_o
    );

    modport slave (
        output op_code, funct, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_dest, mem_reg,
               reg_write, trap, state_o
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM on a shared memory port, with memory stall
// timeout and sticky trapping on illegal op_code/funct.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter bit EN_ADDI     = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    multicycle_control_unit_if.master         bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12,
        TRAP   = 4'd13
    } state_e;

    // Registered Moore strobes. fetch_wr/branch_wr are qualifiers that get
    // combined with mem_ready/zero at the output.
    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  iord;
        logic                  fetch_wr;
        logic                  branch_wr;
        logic                  pc_write;
        logic [1:0]            pc_src;
        logic                  alu_src_a;
        logic [1:0]            alu_src_b;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  reg_dest;
        logic                  mem_reg;
        logic                  reg_write;
        logic                  trap;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        logic [2:0] c;
        c = ALU_ADD;
        case (f)
            FN_SUB:  c = ALU_SUB;
            FN_AND:  c = ALU_AND;
            FN_OR:   c = ALU_OR;
            FN_SLT:  c = ALU_SLT;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    ctrl_t            ctrl_q, ctrl_d;

    logic waiting;
    logic expire;

    // Memory-wait states share one stall counter; a ready in the final
    // allowed cycle still completes the access normally.
    assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign expire  = waiting && !bus.mem_ready && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        if (waiting && !bus.mem_ready && !expire) begin
            tmo_d = tmo_q + 1'b1;
        end
        unique case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  if (bus.mem_ready) state_d = DECODE;
                    else if (expire)   state_d = TRAP;
            DECODE: begin
                case (bus.op_code)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = EN_ADDI ? ADDIEX : TRAP;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: begin
                if (bus.op_code == OP_LW)      state_d = MEMRD;
                else if (bus.op_code == OP_SW) state_d = MEMWR;
                else                           state_d = TRAP;
            end
            MEMRD:  if (bus.mem_ready) state_d = MEMWB;
                    else if (expire)   state_d = TRAP;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (bus.mem_ready) state_d = FETCH;
                    else if (expire)   state_d = TRAP;
            EXEC:   state_d = funct_ok(bus.funct) ? ALUWB : TRAP;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
            TRAP:   state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    // Strobes are decoded from the next state so they come out of flops in
    // the same cycle the state register shows that state.
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            FETCH: begin
                ctrl_d.mem_read    = 1'b1;
                ctrl_d.fetch_wr    = 1'b1;
                ctrl_d.alu_src_b   = 2'b01;
                ctrl_d.alu_control = ALU_CTRL_W'(ALU_ADD);
            end
            DECODE: begin
                ctrl_d.alu_src_b   = 2'b11;
                ctrl_d.alu_control = ALU_CTRL_W'(ALU_ADD);
            end
            MEMADR, ADDIEX: begin
                ctrl_d.alu_src_a   = 1'b1;
                ctrl_d.alu_src_b   = 2'b10;
                ctrl_d.alu_control = ALU_CTRL_W'(ALU_ADD);
            end
            MEMRD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.mem_reg   = 1'b1;
            end
            MEMWR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.iord      = 1'b1;
            end
            EXEC: begin
                ctrl_d.alu_src_a   = 1'b1;
                ctrl_d.alu_control = ALU_CTRL_W'(alu_of(bus.funct));
            end
            ALUWB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dest  = 1'b1;
            end
            BRANCH: begin
                ctrl_d.alu_src_a   = 1'b1;
                ctrl_d.alu_control = ALU_CTRL_W'(ALU_SUB);
                ctrl_d.pc_src      = 2'b01;
                ctrl_d.branch_wr   = 1'b1;
            end
            ADDIWB: ctrl_d.reg_write = 1'b1;
            JUMP: begin
                ctrl_d.pc_src   = 2'b10;
                ctrl_d.pc_write = 1'b1;
            end
            TRAP:   ctrl_d.trap = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.mem_read    = ctrl_q.mem_read;
    assign bus.mem_write   = ctrl_q.mem_write;
    assign bus.iord        = ctrl_q.iord;
    assign bus.ir_write    = ctrl_q.fetch_wr & bus.mem_ready;
    assign bus.pc_write    = ctrl_q.pc_write
                           | (ctrl_q.fetch_wr & bus.mem_ready)
                           | (ctrl_q.branch_wr & bus.zero);
    assign bus.pc_src      = ctrl_q.pc_src;
    assign bus.alu_src_a   = ctrl_q.alu_src_a;
    assign bus.alu_src_b   = ctrl_q.alu_src_b;
    assign bus.alu_control = ctrl_q.alu_control;
    assign bus.reg_dest    = ctrl_q.reg_dest;
    assign bus.mem_reg     = ctrl_q.mem_reg;
    assign bus.reg_write   = ctrl_q.reg_write;
    assign bus.trap        = ctrl_q.trap;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver walks each instruction's phase list and queues
// the expected strobes per cycle; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

    localparam int TMO = 16;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       reg_dest;
        logic       mem_reg;
        logic       reg_write;
        logic       trap;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    alu_dc;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_CTRL_W(3)) bus ();
    multicycle_control_unit_if #(.ALU_CTRL_W(3)) bus2 ();
    assign bus2.op_code   = bus.op_code;
    assign bus2.funct     = bus.funct;
    assign bus2.zero      = bus.zero;
    assign bus2.mem_ready = bus.mem_ready;

    multicycle_control_unit #(.ALU_CTRL_W(3), .TIMEOUT_CYC(TMO), .EN_ADDI(1'b1))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    multicycle_control_unit #(.ALU_CTRL_W(3), .TIMEOUT_CYC(TMO), .EN_ADDI(1'b0))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   trapped = 1'b0;
    int   force_lo = 0;
    bit   rand_rdy = 1'b0;
    int   zero_mode = 0;

    function automatic outs_t actual();
        outs_t a;
        a = '{bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
              bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
              bus.reg_dest, bus.mem_reg, bus.reg_write, bus.trap};
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit funct_legal(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    // Phase letters: F fetch, D decode, A address, R mem read, W load writeback,
    // S mem write, E execute, U alu writeback, B branch, I addi exec, K addi wb, J jump.
    function automatic string phases(input logic [5:0] op, input logic [5:0] fn, output bit ill);
        ill = 1'b0;
        case (op)
            LW:   return "FDARW";
            SW:   return "FDAS";
            RT:   begin
                if (funct_legal(fn)) return "FDEU";
                ill = 1'b1;
                return "FDE";
            end
            BEQ:  return "FDB";
            JMP:  return "FDJ";
            ADDI: return "FDIK";
            default: begin
                ill = 1'b1;
                return "FD";
            end
        endcase
    endfunction

    function automatic exp_t model(input byte p, input bit rdy, input bit z,
                                   input logic [5:0] fn, input bit trp);
        exp_t e;
        e.o = '0;
        e.alu_dc = 1'b0;
        e.cyc = 0;
        if (trp) begin
            e.o.trap = 1'b1;
            return e;
        end
        case (p)
            "F": begin
                e.o.mem_read = 1'b1; e.o.alu_src_b = 2'b01; e.o.alu_control = 3'b010;
                e.o.ir_write = rdy;  e.o.pc_write = rdy;
            end
            "D": begin e.o.alu_src_b = 2'b11; e.o.alu_control = 3'b010; end
            "A", "I": begin e.o.alu_src_a = 1'b1; e.o.alu_src_b = 2'b10; e.o.alu_control = 3'b010; end
            "R": begin e.o.mem_read = 1'b1; e.o.iord = 1'b1; end
            "W": begin e.o.reg_write = 1'b1; e.o.mem_reg = 1'b1; end
            "S": begin e.o.mem_write = 1'b1; e.o.iord = 1'b1; end
            "E": begin
                e.o.alu_src_a = 1'b1;
                case (fn)
                    6'b100000: e.o.alu_control = 3'b010;
                    6'b100010: e.o.alu_control = 3'b110;
                    6'b100100: e.o.alu_control = 3'b000;
                    6'b100101: e.o.alu_control = 3'b001;
                    6'b101010: e.o.alu_control = 3'b111;
                    default:   e.alu_dc = 1'b1;
                endcase
            end
            "U": begin e.o.reg_write = 1'b1; e.o.reg_dest = 1'b1; end
            "B": begin
                e.o.alu_src_a = 1'b1; e.o.alu_control = 3'b110;
                e.o.pc_src = 2'b01;   e.o.pc_write = z;
            end
            "K": e.o.reg_write = 1'b1;
            "J": begin e.o.pc_src = 2'b10; e.o.pc_write = 1'b1; end
            default: e.o = '0;
        endcase
        return e;
    endfunction

    task automatic drive_inputs();
        if (force_lo > 0) begin
            bus.mem_ready = 1'b0;
            force_lo--;
        end else begin
            bus.mem_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        bus.zero = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", 32'(actual()), 32'd0);
        chk("reset_state", 32'(bus.state_o), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("idle_outputs", 32'(actual()), 32'd0);
        chk("idle_state", 32'(bus.state_o), 32'd0);
        trapped = 1'b0;
        force_lo = 0;
    endtask

    task automatic push_cycle(input byte p, input logic [5:0] fn);
        exp_t e;
        e = model(p, bus.mem_ready, bus.zero, fn, trapped);
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit abort);
        string ph;
        bit    ill;
        int    idx;
        int    wt;
        idx = 0;
        wt = 0;
        ph = phases(op, fn, ill);
        bus.op_code = op;
        bus.funct = fn;
        while (idx < ph.len()) begin
            @(posedge clk);
            #1;
            cyc++;
            if (abort && ph[idx] == "S") force_lo = 1;
            drive_inputs();
            push_cycle(ph[idx], fn);
            if ((ph[idx] inside {"F", "R", "S"}) && !bus.mem_ready) begin
                wt++;
                if (abort && wt == 2) begin
                    do_reset();
                    return;
                end
                if (wt == TMO) begin
                    trapped = 1'b1;
                    return;
                end
            end else begin
                wt = 0;
                idx++;
            end
        end
        if (ill) trapped = 1'b1;
    endtask

    task automatic trap_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            drive_inputs();
            push_cycle("T", 6'd0);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        outs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual();
            if (e.alu_dc) a.alu_control = e.o.alu_control;
            checks++;
            if (a !== e.o) begin
                errors++;
                $display("FAIL strobes cycle %0d got %h expected %h", e.cyc, a, e.o);
            end
        end
    end

    initial begin
        logic [5:0] fl [5];
        int         k;
        logic [5:0] op;
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bus.op_code = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        do_reset();
        run_instr(LW, 6'd0, 1'b0);
        run_instr(RT, 6'b100000, 1'b0);
        run_instr(RT, 6'b101010, 1'b0);
        zero_mode = 1;
        run_instr(BEQ, 6'd0, 1'b0);
        zero_mode = 0;
        run_instr(BEQ, 6'd0, 1'b0);
        run_instr(SW, 6'd0, 1'b0);
        run_instr(ADDI, 6'd0, 1'b0);

        force_lo = 5;
        run_instr(JMP, 6'd0, 1'b0);
        force_lo = TMO;
        run_instr(JMP, 6'd0, 1'b0);
        trap_cycles(3);
        do_reset();

        force_lo = 3;
        run_instr(LW, 6'd0, 1'b0);
        force_lo = 1;
        run_instr(LW, 6'd0, 1'b0);

        run_instr(6'b111111, 6'd0, 1'b0);
        trap_cycles(2);
        do_reset();
        run_instr(RT, 6'b000111, 1'b0);
        trap_cycles(2);
        do_reset();

        chk("addi_disabled_pre", 32'(bus2.trap), 32'd0);
        run_instr(ADDI, 6'd0, 1'b0);
        #1;
        chk("addi_disabled_trap", 32'(bus2.trap), 32'd1);

        run_instr(SW, 6'd0, 1'b1);
        run_instr(LW, 6'd0, 1'b0);

        rand_rdy = 1'b1;
        zero_mode = 2;
        repeat (60) begin
            k = $urandom_range(0, 19);
            case (k)
                0, 1, 2:  run_instr(LW, 6'd0, 1'b0);
                3, 4:     run_instr(SW, 6'd0, 1'b0);
                5, 6, 7, 8: run_instr(RT, fl[$urandom_range(0, 4)], 1'b0);
                9, 10, 11: run_instr(BEQ, 6'd0, 1'b0);
                12, 13:   run_instr(JMP, 6'd0, 1'b0);
                14, 15, 16: run_instr(ADDI, 6'd0, 1'b0);
                17:       run_instr(RT, 6'($urandom_range(0, 63)), 1'b0);
                default: begin
                    op = 6'($urandom_range(0, 63));
                    run_instr(op, 6'd0, 1'b0);
                end
            endcase
            if (trapped) begin
                trap_cycles(2);
                do_reset();
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
